// File: rtl/ff_bank.sv
// Bank of WIDTH independent flip-flops whose behaviour (D, T, JK or SR) is chosen at run time.
// Adds an enable, a synchronous clear, a sticky SR-invalid flag and a per-bit change report.
module ff_bank #(
   parameter int                 WIDTH   = 8,
   parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         mode,
   input  logic               en,
   input  logic               clr,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   q,
   output logic [WIDTH-1:0]   qn,
   output logic [WIDTH-1:0]   chg,
   output logic               err_sr
);

   localparam logic [1:0] MODE_D  = 2'b00;
   localparam logic [1:0] MODE_T  = 2'b01;
   localparam logic [1:0] MODE_JK = 2'b10;
   localparam logic [1:0] MODE_SR = 2'b11;

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] chg_q, chg_d;
   logic             err_q, err_d;

   always_comb begin
      q_d   = q_q;
      err_d = err_q;
      if (clr) begin
         q_d   = RST_VAL;
         err_d = 1'b0;
      end else if (en) begin
         // a and b are only looked at inside the enable, so X inputs cannot leak in while idle.
         for (int i = 0; i < WIDTH; i++) begin
            case (mode)
               MODE_D:  q_d[i] = a[i];
               MODE_T:  q_d[i] = q_q[i] ^ a[i];
               MODE_JK: begin
                  case ({a[i], b[i]})
                     2'b01:   q_d[i] = 1'b0;
                     2'b10:   q_d[i] = 1'b1;
                     2'b11:   q_d[i] = ~q_q[i];
                     default: q_d[i] = q_q[i];
                  endcase
               end
               default: begin
                  case ({a[i], b[i]})
                     2'b01:   q_d[i] = 1'b0;
                     2'b10:   q_d[i] = 1'b1;
                     default: q_d[i] = q_q[i];
                  endcase
               end
            endcase
         end
         if ((mode == MODE_SR) && |(a & b))
            err_d = 1'b1;
      end
      chg_d = q_d ^ q_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q   <= RST_VAL;
         chg_q <= '0;
         err_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         chg_q <= chg_d;
         err_q <= err_d;
      end
   end

   assign q      = q_q;
   assign qn     = ~q_q;
   assign chg    = chg_q;
   assign err_sr = err_q;

endmodule

// File: tb/tb_ff_bank.sv
// Directed bench for ff_bank with WIDTH=8, RST_VAL=8'hA5; each task drives one scenario and checks inline.
module tb_ff_bank;

   localparam int         W    = 8;
   localparam logic [7:0] RV   = 8'hA5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   mode;
   logic         en, clr;
   logic [W-1:0] a, b;
   logic [W-1:0] q, qn, chg;
   logic         err_sr;

   int n_cmp = 0;
   int n_err = 0;

   ff_bank #(.WIDTH(W), .RST_VAL(RV)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .clr(clr),
      .a(a), .b(b), .q(q), .qn(qn), .chg(chg), .err_sr(err_sr)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; one rising edge passes before the next falling-edge sample.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b1; mode = 2'b00; en = 1'b0; clr = 1'b0; a = '0; b = '0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (q !== 8'hA5)    begin n_err++; $display("FAIL reset_q got %h exp a5", q); end
      n_cmp++; if (qn !== 8'h5A)   begin n_err++; $display("FAIL reset_qn got %h exp 5a", qn); end
      n_cmp++; if (chg !== 8'h00)  begin n_err++; $display("FAIL reset_chg got %h exp 00", chg); end
      n_cmp++; if (err_sr !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", err_sr); end
      step();
      rst_n = 1'b1;
      step();
      n_cmp++; if (q !== 8'hA5)    begin n_err++; $display("FAIL release_hold_q got %h exp a5", q); end
      n_cmp++; if (chg !== 8'h00)  begin n_err++; $display("FAIL release_hold_chg got %h exp 00", chg); end
   endtask

   task automatic test_d_mode();
      mode = 2'b00; en = 1'b1; a = 8'h3C;
      step();
      n_cmp++; if (q !== 8'h3C)    begin n_err++; $display("FAIL d_q got %h exp 3c", q); end
      n_cmp++; if (chg !== 8'h99)  begin n_err++; $display("FAIL d_chg got %h exp 99", chg); end
      n_cmp++; if (qn !== 8'hC3)   begin n_err++; $display("FAIL d_qn got %h exp c3", qn); end
      en = 1'b0; a = 8'hFF;
      step();
      n_cmp++; if (q !== 8'h3C)    begin n_err++; $display("FAIL d_en0_q got %h exp 3c", q); end
      n_cmp++; if (chg !== 8'h00)  begin n_err++; $display("FAIL d_en0_chg got %h exp 00", chg); end
   endtask

   task automatic test_t_mode();
      logic [7:0] exp_full [3];
      logic [7:0] exp_lsb  [4];
      exp_full = '{8'hFF, 8'h00, 8'hFF};
      exp_lsb  = '{8'hFE, 8'hFF, 8'hFE, 8'hFF};
      mode = 2'b00; en = 1'b1; a = 8'h00;
      step();
      mode = 2'b01; a = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (q !== exp_full[i]) begin n_err++; $display("FAIL t_ff_q[%0d] got %h exp %h", i, q, exp_full[i]); end
         n_cmp++; if (chg !== 8'hFF)     begin n_err++; $display("FAIL t_ff_chg[%0d] got %h exp ff", i, chg); end
      end
      a = 8'h01;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++; if (q !== exp_lsb[i]) begin n_err++; $display("FAIL t_01_q[%0d] got %h exp %h", i, q, exp_lsb[i]); end
         n_cmp++; if (chg !== 8'h01)    begin n_err++; $display("FAIL t_01_chg[%0d] got %h exp 01", i, chg); end
      end
   endtask

   task automatic test_jk_mode();
      mode = 2'b00; en = 1'b1; a = 8'h0F;
      step();
      mode = 2'b10; a = 8'hF0; b = 8'h3C;
      step();
      n_cmp++; if (q !== 8'hF3)   begin n_err++; $display("FAIL jk_q got %h exp f3", q); end
      n_cmp++; if (chg !== 8'hFC) begin n_err++; $display("FAIL jk_chg got %h exp fc", chg); end
   endtask

   task automatic test_sr_invalid();
      mode = 2'b11; en = 1'b1; a = 8'h01; b = 8'h01;
      step();
      n_cmp++; if (q !== 8'hF3)     begin n_err++; $display("FAIL sr11_q got %h exp f3", q); end
      n_cmp++; if (err_sr !== 1'b1) begin n_err++; $display("FAIL sr11_err got %b exp 1", err_sr); end
      n_cmp++; if (chg !== 8'h00)   begin n_err++; $display("FAIL sr11_chg got %h exp 00", chg); end
      a = 8'h0C; b = 8'h01;
      step();
      n_cmp++; if (q !== 8'hFE)     begin n_err++; $display("FAIL sr_set_q got %h exp fe", q); end
      n_cmp++; if (chg !== 8'h0D)   begin n_err++; $display("FAIL sr_set_chg got %h exp 0d", chg); end
      n_cmp++; if (err_sr !== 1'b1) begin n_err++; $display("FAIL sr_sticky_err got %b exp 1", err_sr); end
      en = 1'b0; clr = 1'b1;
      step();
      clr = 1'b0;
      n_cmp++; if (q !== 8'hA5)     begin n_err++; $display("FAIL clr_q got %h exp a5", q); end
      n_cmp++; if (err_sr !== 1'b0) begin n_err++; $display("FAIL clr_err got %b exp 0", err_sr); end
      n_cmp++; if (chg !== 8'h5B)   begin n_err++; $display("FAIL clr_chg got %h exp 5b", chg); end
   endtask

   task automatic test_priority();
      mode = 2'b01; en = 1'b1; a = 8'hFF; clr = 1'b1;
      step();
      clr = 1'b0;
      n_cmp++; if (q !== 8'hA5)   begin n_err++; $display("FAIL clr_wins_q got %h exp a5", q); end
      n_cmp++; if (chg !== 8'h00) begin n_err++; $display("FAIL clr_wins_chg got %h exp 00", chg); end
      en = 1'b0; a = 'x; b = 'x;
      step();
      n_cmp++; if (q !== 8'hA5)   begin n_err++; $display("FAIL x_idle_q got %h exp a5", q); end
      n_cmp++; if (chg !== 8'h00) begin n_err++; $display("FAIL x_idle_chg got %h exp 00", chg); end
      mode = 2'b11; en = 1'b1; a = 8'h01; b = 8'h01;
      step();
      mode = 2'b01; a = 8'hFF; b = 8'h00;
      step();
      n_cmp++; if (q !== 8'h5A)     begin n_err++; $display("FAIL active_q got %h exp 5a", q); end
      n_cmp++; if (err_sr !== 1'b1) begin n_err++; $display("FAIL active_err got %b exp 1", err_sr); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (q !== 8'hA5)     begin n_err++; $display("FAIL midrst_q got %h exp a5", q); end
      n_cmp++; if (chg !== 8'h00)   begin n_err++; $display("FAIL midrst_chg got %h exp 00", chg); end
      n_cmp++; if (err_sr !== 1'b0) begin n_err++; $display("FAIL midrst_err got %b exp 0", err_sr); end
      step();
      rst_n = 1'b1; a = 8'h0F;
      step();
      n_cmp++; if (q !== 8'hAA)   begin n_err++; $display("FAIL resume_q got %h exp aa", q); end
      n_cmp++; if (chg !== 8'h0F) begin n_err++; $display("FAIL resume_chg got %h exp 0f", chg); end
   endtask

   initial begin
      test_reset();
      test_d_mode();
      test_t_mode();
      test_jk_mode();
      test_sr_invalid();
      test_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
